ahb_reg_slave: RTL

Parametrised AHB-Lite slave register block: a bank of NUM_RW read/write control registers followed by NUM_RO read-only status words, with byte-lane writes, programmable wait states and the two-cycle ERROR response. It sits behind the AHB decoder as one HSEL target. It generalises the fixed 8-bit, two-payload-register interface to arbitrary data width, register count and wait-state count, and adds protocol-correct error signalling.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahb_lane_decode.sv | 34 +++
 rtl/ahb_reg_slave.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the register slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_t;

endpackage

// File: rtl/ahb_lane_decode.sv
// Byte-lane strobes plus misalign/oversize flags for one AHB address phase.
module ahb_lane_decode
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]              addr_lo,
  input  logic [2:0]              size,
  output logic [DATA_WIDTH/8-1:0] strb,
  output logic                    misalign,
  output logic                    oversize
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned LOG_NB = $clog2(NB);

  logic [3:0] mask;
  logic [3:0] off;
  logic [3:0] nbytes;

  always_comb begin
    // Sizes of 16 bytes and above wrap mask to all-ones; they are oversize anyway.
    mask     = (4'd1 << size) - 4'd1;
    misalign = |({1'b0, addr_lo} & mask);
    oversize = (size > 3'(LOG_NB)) || (size > HSIZE_WORD);
    off      = {1'b0, addr_lo} & 4'(NB - 1);
    nbytes   = 4'd1 << size;
    strb     = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if ((4'(i) >= off) && (4'(i) < off + nbytes)) strb[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_reg_slave.sv
// AHB-Lite register slave: RW bank, RO status words, byte-lane writes, wait states, 2-cycle ERROR.
module ahb_reg_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned NUM_RW      = 4,
  parameter int unsigned NUM_RO      = 2,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                         hclk,
  input  logic                         hreset_n,
  input  logic                         hsel,
  input  logic [ADDR_WIDTH-1:0]        haddr,
  input  logic [1:0]                   htrans,
  input  logic                         hwrite,
  input  logic [2:0]                   hsize,
  input  logic [DATA_WIDTH-1:0]        hwdata,
  input  logic                         hready,
  input  logic [NUM_RO*DATA_WIDTH-1:0] ro_status,
  output logic [DATA_WIDTH-1:0]        hrdata,
  output logic                         hreadyout,
  output logic                         hresp,
  output logic [NUM_RW*DATA_WIDTH-1:0] rw_regs,
  output logic [NUM_RW-1:0]            wr_pulse
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned LOG_NB = $clog2(NB);
  localparam int unsigned NUM_W  = NUM_RW + NUM_RO;

  slv_state_t                  state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]       haddr_q;
  logic                        write_q;
  logic [NB-1:0]               strb_q;
  logic [NUM_RW*DATA_WIDTH-1:0] rw_q;
  logic [NUM_RW-1:0]           wr_pulse_q;

  logic [NB-1:0]         strb_in;
  logic                  misalign, oversize;
  logic [ADDR_WIDTH-1:0] idx_in, idx_q;
  logic                  accept, take, dec_err;

  ahb_lane_decode #(.DATA_WIDTH(DATA_WIDTH)) u_lane_decode (
    .addr_lo  (haddr[2:0]),
    .size     (hsize),
    .strb     (strb_in),
    .misalign (misalign),
    .oversize (oversize)
  );

  assign idx_in  = haddr >> LOG_NB;
  assign idx_q   = haddr_q >> LOG_NB;
  assign accept  = hsel && hready &&
                   ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign dec_err = misalign || oversize ||
                   (idx_in >= ADDR_WIDTH'(NUM_W)) ||
                   (hwrite && (idx_in >= ADDR_WIDTH'(NUM_RW)));
  // A new address phase can only be taken while our own data phase is not stalling.
  assign take    = accept && ((state_q == ST_IDLE) || (state_q == ST_DATA) ||
                              (state_q == ST_ERR2));

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      haddr_q <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        haddr_q <= haddr;
        write_q <= hwrite;
        strb_q  <= strb_in;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        hreadyout = 1'b0;
        cnt_d     = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = ST_DATA;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ST_ERR2;
      end
      default: begin
        if (state_q == ST_ERR2) hresp = 1'b1;
        state_d = ST_IDLE;
        if (take) begin
          if (dec_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = 2'(WAIT_STATES);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      rw_q       <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if ((state_q == ST_DATA) && write_q) begin
        for (int unsigned r = 0; r < NUM_RW; r++) begin
          if (idx_q == ADDR_WIDTH'(r)) begin
            wr_pulse_q[r] <= 1'b1;
            for (int unsigned b = 0; b < NB; b++) begin
              if (strb_q[b]) rw_q[r*DATA_WIDTH + b*8 +: 8] <= hwdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if ((state_q == ST_DATA) && !write_q) begin
      for (int unsigned r = 0; r < NUM_RW; r++) begin
        if (idx_q == ADDR_WIDTH'(r)) hrdata = rw_q[r*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int unsigned k = 0; k < NUM_RO; k++) begin
        if (idx_q == ADDR_WIDTH'(NUM_RW + k)) hrdata = ro_status[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rw_regs  = rw_q;
  assign wr_pulse = wr_pulse_q;

endmodule
